// File: rtl/counter_ctrl.sv
// counter_ctrl
// Sequencing controller for a 4-bit up-counter. A start command, sampled
// only in IDLE, latches a target count and a repeat count. The controller
// then runs that many passes. Each pass is one clear cycle followed by
// counting up to the target.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   command strobe, accepted only in IDLE
//   target[3:0]   in   count value that ends each pass (latched on start)
//   repeats[3:0]  in   number of passes, 0 means 1 (latched on start)
//   pause      in   level, forces cnt_enable low while high
//   abort      in   level, ends a run in CLEAR or RUN
//   count[3:0]    in   registered counter output
//   cnt_enable out  counter enable (combinational)
//   cnt_clear  out  counter synchronous clear (registered)
//   busy       out  high in CLEAR and RUN
//   done       out  one-cycle pulse on normal completion
//   aborted    out  one-cycle pulse on abort
//   pass_idx[3:0] out  current pass index, starting at 0
//   dbg_state[2:0] out FSM state for observation (0 IDLE, 1 CLEAR, 2 RUN,
//                      3 DONE, 4 ABRT)
//
// Command handshake: there is no ready signal. A start is accepted exactly
// when it is high at a rising edge while the FSM is in IDLE. A start in any
// other state is dropped, not queued.

module counter_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] target,
  input  logic [3:0] repeats,
  input  logic       pause,
  input  logic       abort,
  input  logic [3:0] count,
  output logic       cnt_enable,
  output logic       cnt_clear,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [3:0] pass_idx,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ABRT  = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_tgt;
  logic [3:0] r_rep;
  logic [3:0] r_pass_idx;
  logic [3:0] w_pass_next;
  logic       w_load;
  logic [3:0] w_rep_in;
  logic       w_hit;
  logic       w_last;
  logic       r_cnt_clear;
  logic       r_busy;
  logic       r_done;
  logic       r_aborted;

  assign w_rep_in = (repeats == 4'd0) ? 4'd1 : repeats;
  assign w_hit    = (count == r_tgt);
  // r_rep is never 0 after a load, so rep-1 does not underflow.
  assign w_last   = (r_pass_idx == (r_rep - 4'd1));

  // Next-state logic. abort is checked before completion so that an abort
  // in the completing cycle yields only the aborted pulse.
  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_pass_next = r_pass_idx;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_pass_next = 4'd0;
          w_next      = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (abort) w_next = S_ABRT;
        else       w_next = S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          w_next = S_ABRT;
        end else if (w_hit) begin
          if (w_last) begin
            w_next = S_DONE;
          end else begin
            w_pass_next = r_pass_idx + 4'd1;
            w_next      = S_CLEAR;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ABRT:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tgt      <= 4'd0;
      r_rep      <= 4'd0;
      r_pass_idx <= 4'd0;
    end else begin
      r_state    <= w_next;
      r_pass_idx <= w_pass_next;
      if (w_load) begin
        r_tgt <= target;
        r_rep <= w_rep_in;
      end
    end
  end

  // Moore outputs registered from the next state, so they line up with the
  // state they describe and come straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt_clear <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_cnt_clear <= (w_next == S_CLEAR);
      r_busy      <= (w_next == S_CLEAR) || (w_next == S_RUN);
      r_done      <= (w_next == S_DONE);
      r_aborted   <= (w_next == S_ABRT);
    end
  end

  // Counting stops at the target on its own. pause only gates counting, so
  // completion is still seen while paused.
  assign cnt_enable = (r_state == S_RUN) & ~pause & ~w_hit;
  assign cnt_clear  = r_cnt_clear;
  assign busy       = r_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign pass_idx   = r_pass_idx;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] target;
  logic [3:0] repeats;
  logic       pause;
  logic       abort;
  logic [3:0] count;
  logic       cnt_enable;
  logic       cnt_clear;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [3:0] pass_idx;
  logic [2:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  counter_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .target     (target),
    .repeats    (repeats),
    .pause      (pause),
    .abort      (abort),
    .count      (count),
    .cnt_enable (cnt_enable),
    .cnt_clear  (cnt_clear),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .pass_idx   (pass_idx),
    .dbg_state  (dbg_state)
  );

  // Model of the 4-bit counter being controlled, on the same system reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          count <= 4'd0;
    else if (cnt_clear)  count <= 4'd0;
    else if (cnt_enable) count <= count + 4'd1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Per-run observations, indexed by k = rising edges since the start edge.
  int         clr_n, en_n, busy_n, done_n, abrt_n, done_k, abrt_k, end_k;
  logic [3:0] max_cnt, end_cnt;
  logic [11:0] clr_seq;

  // ---------------- driver ----------------
  // Issues one start, then watches up to 64 cycles. pause_n cycles of pause
  // are applied while count==1. abort_cnt>=0 raises abort for one cycle in
  // RUN when count equals it (optionally together with pause). start_mid
  // pulses start again in cycle k==2.
  task automatic run_seq(input logic [3:0] tgt, input logic [3:0] rep, input int pause_n,
                         input int abort_cnt, input logic abort_with_pause,
                         input logic start_mid);
    int   pause_left;
    logic abort_sent;
    pause_left = pause_n;
    abort_sent = 1'b0;
    clr_n = 0; en_n = 0; busy_n = 0; done_n = 0; abrt_n = 0;
    done_k = -1; abrt_k = -1; end_k = -1;
    max_cnt = 4'd0; end_cnt = 4'd0; clr_seq = 12'd0;
    @(negedge clk);
    target  = tgt;
    repeats = rep;
    start   = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 64; k++) begin
      start = start_mid && (k == 2);
      pause = 1'b0;
      abort = 1'b0;
      if (pause_left > 0 && count == 4'd1 && dbg_state == 3'd2) begin
        pause = 1'b1;
        pause_left--;
      end
      if (abort_cnt >= 0 && !abort_sent && dbg_state == 3'd2 && count == abort_cnt[3:0]) begin
        abort      = 1'b1;
        abort_sent = 1'b1;
        if (abort_with_pause) pause = 1'b1;
      end
      #1;
      if (cnt_clear) begin
        clr_n++;
        clr_seq = {clr_seq[7:0], pass_idx};
      end
      if (cnt_enable) en_n++;
      if (busy) busy_n++;
      if (count > max_cnt) max_cnt = count;
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (aborted) begin
        abrt_n++;
        if (abrt_k < 0) abrt_k = k;
      end
      if (end_k < 0 && (done || aborted)) begin
        end_k   = k;
        end_cnt = count;
      end
      if (end_k >= 0 && k >= end_k + 2) break;
      @(negedge clk);
    end
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
  endtask

  // ---------------- directed steps ----------------
  initial begin
    reset = 1'b0; start = 1'b0; target = 4'd0; repeats = 4'd0;
    pause = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_clear", cnt_clear, 0);
    check("rst_enable", cnt_enable, 0);
    check("rst_pass_idx", pass_idx, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single pass, target 3.
    run_seq(4'd3, 4'd1, 0, -1, 1'b0, 1'b0);
    check("p1_done_k", done_k, 5);
    check("p1_done_n", done_n, 1);
    check("p1_clr_n", clr_n, 1);
    check("p1_en_n", en_n, 3);
    check("p1_busy_n", busy_n, 5);
    check("p1_end_cnt", end_cnt, 3);
    check("p1_max_cnt", max_cnt, 3);
    check("p1_idle", dbg_state, 0);

    // Three passes, target 2.
    run_seq(4'd2, 4'd3, 0, -1, 1'b0, 1'b0);
    check("mp_done_k", done_k, 12);
    check("mp_clr_n", clr_n, 3);
    check("mp_clr_seq", clr_seq, 12'h012);
    check("mp_en_n", en_n, 6);
    check("mp_end_cnt", end_cnt, 2);
    check("mp_pass_hold", pass_idx, 2);

    // Target 4 with three pause cycles at count 1.
    run_seq(4'd4, 4'd1, 3, -1, 1'b0, 1'b0);
    check("pz_done_k", done_k, 9);
    check("pz_en_n", en_n, 4);
    check("pz_max_cnt", max_cnt, 4);
    check("pz_pass_idx", pass_idx, 0);

    // Target 0, repeats 0 treated as one pass.
    run_seq(4'd0, 4'd0, 0, -1, 1'b0, 1'b0);
    check("t0_done_k", done_k, 2);
    check("t0_en_n", en_n, 0);
    check("t0_done_n", done_n, 1);

    // Abort at count 2 of target 5; pause held with it so nothing counts
    // on the abort edge.
    run_seq(4'd5, 4'd1, 0, 2, 1'b1, 1'b0);
    check("ab_abrt_k", abrt_k, 4);
    check("ab_abrt_n", abrt_n, 1);
    check("ab_done_n", done_n, 0);
    check("ab_end_cnt", end_cnt, 2);
    check("ab_clr_n", clr_n, 1);
    check("ab_idle", dbg_state, 0);
    check("ab_cnt_hold", count, 2);

    // Abort in the same cycle as completion (target 1 reached).
    run_seq(4'd1, 4'd1, 0, 1, 1'b0, 1'b0);
    check("abc_abrt_k", abrt_k, 3);
    check("abc_abrt_n", abrt_n, 1);
    check("abc_done_n", done_n, 0);

    // Second start during RUN is dropped.
    run_seq(4'd3, 4'd1, 0, -1, 1'b0, 1'b1);
    check("sm_done_k", done_k, 5);
    check("sm_done_n", done_n, 1);
    check("sm_busy_n", busy_n, 5);
    check("sm_idle", dbg_state, 0);

    // Reset mid-pass.
    @(negedge clk);
    target = 4'd6; repeats = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mr_busy_before", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_enable", cnt_enable, 0);
    check("mr_clear", cnt_clear, 0);
    check("mr_done", done, 0);
    check("mr_aborted", aborted, 0);
    check("mr_pass_idx", pass_idx, 0);
    check("mr_state", dbg_state, 0);
    check("mr_count", count, 0);
    @(negedge clk);
    reset = 1'b1;

    // Normal run after reset release.
    run_seq(4'd2, 4'd2, 0, -1, 1'b0, 1'b0);
    check("ar_done_k", done_k, 8);
    check("ar_clr_n", clr_n, 2);
    check("ar_end_cnt", end_cnt, 2);
    check("ar_pass_idx", pass_idx, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
